sbox_layer_seq: RTL and testbench

SBOX_LAYER_SEQ -- requirements
Module: sbox_layer_seq

---
 rtl/sbox_layer_seq.sv | 189 ++++++++++++++++++
 tb/tb_sbox_layer_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: applies the 4-bit PRESENT substitution to every nibble of a
// WIDTH-bit state, one nibble per clock (LSB nibble first), through a single
// shared sbox instance. Valid/ready handshakes on both input and output.
// The file also contains the sbox itself and a small assertion checker.

module present_sbox (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Fixed PRESENT substitution table.
    always_comb begin
        nib_out = 4'h0;
        case (nib_in)
            4'h0:    nib_out = 4'hC;
            4'h1:    nib_out = 4'h5;
            4'h2:    nib_out = 4'h6;
            4'h3:    nib_out = 4'hB;
            4'h4:    nib_out = 4'h9;
            4'h5:    nib_out = 4'h0;
            4'h6:    nib_out = 4'hA;
            4'h7:    nib_out = 4'hD;
            4'h8:    nib_out = 4'h3;
            4'h9:    nib_out = 4'hE;
            4'hA:    nib_out = 4'hF;
            4'hB:    nib_out = 4'h8;
            4'hC:    nib_out = 4'h4;
            4'hD:    nib_out = 4'h7;
            4'hE:    nib_out = 4'h1;
            4'hF:    nib_out = 4'h2;
            default: nib_out = 4'h0;
        endcase
    end

endmodule

module sbox_layer_seq_chk #(
    parameter int WIDTH = 64
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             busy,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data
);

    // Exactly one of the three phase flags is high at any time.
    a_phase_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot({in_ready, busy, out_valid}));

    // A result that is not taken stays valid and unchanged.
    a_result_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

module sbox_layer_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] data_shift_s;
    logic [3:0]       sbox_in_s;
    logic [3:0]       sbox_out_s;

    // Route the nibble addressed by the counter to the shared sbox.
    always_comb begin
        data_shift_s = data_q >> {cnt_q, 2'b00};
        sbox_in_s    = data_shift_s[3:0];
    end

    present_sbox u_sbox (
        .nib_in  (sbox_in_s),
        .nib_out (sbox_out_s)
    );

    // Next-state, datapath update and decoded phase flags for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SUB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SUB: begin
                // Only the addressed nibble takes the sbox result.
                for (int i = 0; i < NIB; i++) begin
                    data_d[4*i +: 4] = (cnt_q == CW'(i)) ? sbox_out_s : data_q[4*i +: 4];
                end
                if (cnt_q == CNT_LAST) begin
                    // Counter parks on the last index; it is cleared on the next accept.
                    cnt_d   = cnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_SUB;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                data_d  = data_q;
            end
        endcase
        // Flags are registered alongside the state so they change on the same edge.
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_SUB);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, counter, data and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            data_q      <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

    sbox_layer_seq_chk #(.WIDTH(WIDTH)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready_q),
        .busy      (busy_q),
        .out_valid (out_valid_q),
        .out_ready (out_ready),
        .out_data  (data_q)
    );

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Scoreboard bench for sbox_layer_seq (WIDTH=64): directed vectors plus a
// randomized phase, checked against a table-lookup model of the sbox layer.

module tb_sbox_layer_seq;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           acc_log[$];

    sbox_layer_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] ref_layer(input logic [W-1:0] x);
        logic [3:0]   tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                   4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 4; i++) begin
            r[4*i +: 4] = tbl[x[4*i +: 4]];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: records accepts, compares every presented result against the queue.
    initial begin
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                chk("phase_onehot", W'($countones({in_ready, busy, out_valid})), W'(1));
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_layer(in_data));
                    acc_q.push_back(cyc);
                    acc_log.push_back(cyc);
                end
                if (out_valid) begin
                    total = total + 1;
                    if (exp_q.size() == 0) begin
                        bad = bad + 1;
                        $display("FAIL unexpected_valid: got out_valid=1 data=%h expected no pending result", out_data);
                    end else begin
                        chk("result", out_data, exp_q[0]);
                        if (!prev_ov) begin
                            chk("latency", W'(cyc - acc_q[0]), W'(17));
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                        end
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("FAIL accept_timeout: got no in_ready expected accept within 60 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [W-1:0] expc);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("FAIL %s_timeout: got no out_valid expected result within 60 cycles", name);
        end else begin
            chk(name, out_data, expc);
        end
    endtask

    initial begin
        int n0;
        int nv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_out_data", out_data, '0);

        // All-zero word.
        send(64'h0000000000000000);
        wait_valid("vec_zero", 64'hCCCCCCCCCCCCCCCC);
        @(posedge clk);

        // Every nibble value once.
        send(64'h0123456789ABCDEF);
        wait_valid("vec_count", 64'hC56B90AD3EF84712);
        @(posedge clk);
        @(negedge clk);
        chk("idle_holds_result", out_data, 64'hC56B90AD3EF84712);

        // Output stall.
        #1;
        out_ready = 1'b0;
        send(64'hFFFFFFFFFFFFFFFF);
        wait_valid("vec_ones", 64'h2222222222222222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", W'(out_valid), W'(1));
            chk("stall_data", out_data, 64'h2222222222222222);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", W'(in_ready), W'(1));
        chk("release_out_valid", W'(out_valid), W'(0));

        // New data offered during SUB must be ignored.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 64'hA5A5_0F0F_1234_5678;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_data = 64'h5A5A_F0F0_8765_4321;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sub_in_ready", W'(in_ready), W'(0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid("vec_first_only", ref_layer(64'hA5A5_0F0F_1234_5678));
        @(posedge clk);

        // Reset at the 8th SUB cycle.
        send(64'hDEAD_BEEF_CAFE_F00D);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_out_data", out_data, '0);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) nv = nv + 1;
        end
        chk("abort_no_valid", W'(nv), W'(0));

        // Back-to-back with in_valid and out_ready held high.
        n0 = acc_log.size();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1111_2222_3333_4444;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_data = 64'h9876_5432_10FE_DCBA;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        total = total + 1;
        if (acc_log.size() < n0 + 2) begin
            bad = bad + 1;
            $display("FAIL b2b_accepts: got %0d expected %0d", acc_log.size() - n0, 2);
        end else begin
            chk("b2b_spacing", W'(acc_log[n0+1] - acc_log[n0]), W'(18));
        end

        // Randomized traffic with output back-pressure.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", W'(exp_q.size()), W'(0));
        total = total + 1;
        if (acc_log.size() < n0 + 10) begin
            bad = bad + 1;
            $display("FAIL random_accepts: got %0d expected at least 10", acc_log.size() - n0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
